// File: rtl/traffic_pkg.sv
// Shared traffic definitions: vehicle light codes and the pedestrian controller state type.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // One-hot so the indications come straight off the state register bits.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    WALK  = 3'b010,
    FLASH = 3'b100
  } ped_state_t;

  function automatic logic is_legal_light(input logic [2:0] light);
    return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// Bus between the traffic light side (master) and the pedestrian crossing controller (slave).
interface ped_crossing_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [2:0]       light;
  logic             ped_btn;
  logic             walk;
  logic             walk_flash;
  logic             dont_walk;
  logic             req_pending;
  logic [CNT_W-1:0] countdown;
  logic             fault;

  modport master (
    output light, ped_btn,
    input  walk, walk_flash, dont_walk, req_pending, countdown, fault
  );

  modport slave (
    input  light, ped_btn,
    output walk, walk_flash, dont_walk, req_pending, countdown, fault
  );
endinterface

// File: rtl/rise_edge_detect.sv
// One-register rising-edge detector with asynchronous active-high reset.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic hist_d, hist_q;

  always_comb hist_d = d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 1'b0;
    else       hist_q <= hist_d;
  end

  assign rise = d & ~hist_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants timed WALK/FLASH on red entry with a latched request.
// Define PED_COUNTDOWN_EN to expose the live interval count on countdown (tied to 0 otherwise).
module ped_crossing_ctrl
  import traffic_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input logic             clk,
  input logic             reset,
  ped_crossing_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);

  ped_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             fault_q, fault_d;
  logic [2:0]       prev_light_q, prev_light_d;

  logic btn_rise;
  logic red_entry;
  logic illegal;
  logic is_red;
  logic enter_walk;

  rise_edge_detect u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.ped_btn),
    .rise  (btn_rise)
  );

  assign is_red    = (bus.light == LIGHT_RED);
  assign illegal   = !is_legal_light(bus.light);
  assign red_entry = is_red && (prev_light_q != LIGHT_RED);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_walk   = 1'b0;
    fault_d      = fault_q | illegal;
    prev_light_d = bus.light;

    if (fault_q || illegal) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (red_entry && req_q) begin
            state_d    = WALK;
            cnt_d      = WALK_LOAD;
            enter_walk = 1'b1;
          end
        end
        WALK: begin
          if (!is_red) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = FLASH;
            cnt_d   = FLASH_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        FLASH: begin
          if (!is_red || cnt_q == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A press coinciding with WALK entry wins, so that request survives for the next red.
    if (btn_rise)        req_d = 1'b1;
    else if (enter_walk) req_d = 1'b0;
    else                 req_d = req_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      fault_q      <= 1'b0;
      prev_light_q <= LIGHT_RED;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      fault_q      <= fault_d;
      prev_light_q <= prev_light_d;
    end
  end

  assign bus.dont_walk   = state_q[0];
  assign bus.walk        = state_q[1];
  assign bus.walk_flash  = state_q[2];
  assign bus.req_pending = req_q;
  assign bus.fault       = fault_q;

`ifdef PED_COUNTDOWN_EN
  assign bus.countdown = cnt_q;
`else
  assign bus.countdown = '0;
`endif

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller that sits directly downstream of the traffic light FSM and consumes its 3-bit one-hot `light` bus ([Red, Yellow, Green]). It latches pedestrian button requests, grants a timed WALK then flashing-WALK interval each time the vehicle light enters RED with a request pending, and holds DON'T WALK otherwise. It also flags any illegal light code as a sticky fault.

## Interface
- `WALK_CYCLES`, default 8: number of cycles `walk` is asserted per grant; legal range 1 to 2^CNT_W.
- `FLASH_CYCLES`, default 4: number of cycles `walk_flash` is asserted after WALK; legal range 1 to 2^CNT_W.
- `CNT_W`, default 4: countdown width.
- `clk` input 1: rising-edge clock, the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `light` input 3: vehicle light from the traffic FSM; 100 = red, 010 = yellow, 001 = green.
- `ped_btn` input 1: pedestrian button, synchronous to `clk`, level.
- `walk` output 1: steady WALK indication.
- `walk_flash` output 1: flashing-WALK (clearance) indication.
- `dont_walk` output 1: DON'T WALK indication.
- `req_pending` output 1: a request is latched and awaiting RED.
- `countdown` output CNT_W: cycles remaining in the current WALK or FLASH interval.
- `fault` output 1: sticky illegal-light flag.

## Operation
- States: IDLE, WALK, FLASH. Exactly one of `dont_walk` (IDLE), `walk` (WALK), or `walk_flash` (FLASH) is 1 at all times.
- Request latch:
  - A rising edge of `ped_btn` sets `req_pending`. The edge is detected as `ped_btn`=1 with its registered copy = 0.
  - `req_pending` clears on the edge that enters WALK.
  - A press in the same cycle as WALK entry is not lost. Its set takes priority, so `req_pending` stays 1.
  - Presses during WALK or FLASH latch a new request.
- Red entry: `light`=100 while the registered previous light is not 100.
- IDLE to WALK: red entry and `req_pending`=1. Load `countdown` = WALK_CYCLES-1.
- WALK:
  - Decrement `countdown` each cycle.
  - At `countdown`=0, go to FLASH and load FLASH_CYCLES-1.
- FLASH: decrement `countdown` each cycle. At 0, go to IDLE and set `countdown` to 0.
- Abort: in WALK or FLASH, if `light` is not 100, go to IDLE next edge and set `countdown` to 0. The request is not re-queued.
- Fault:
  - Any `light` value outside {100, 010, 001} sets `fault`, which is cleared only by reset.
  - While `fault`=1, the block is forced to IDLE, ignores red entry, and still latches requests.
- A request pending at an abort, or arriving mid-red, waits for the next red entry. It never starts mid-red.

## Timing
- All outputs are registered. Reset values:
  - `dont_walk`=1
  - `walk`=0
  - `walk_flash`=0
  - `req_pending`=0
  - `countdown`=0
  - `fault`=0
  - previous-light register = 100, so RED immediately after reset is not an entry
  - button history = 0
- Latency: red entry sampled at edge N means `walk`=1 from edge N+1.
- `walk` is high exactly WALK_CYCLES cycles and `walk_flash` exactly FLASH_CYCLES cycles, provided `light` stays 100 throughout.
- Illegal light at edge N means `fault`=1 and `dont_walk`=1 from edge N+1. This applies in any state, mid-walk included.
- Asynchronous reset mid-WALK forces the reset values immediately. The pending request is discarded.

## Configuration
- `PED_COUNTDOWN_EN` defined: `countdown` outputs the live remaining count as specified.
- `PED_COUNTDOWN_EN` undefined: `countdown` is tied to 0.
  - The interval counter is still present internally for sequencing.
  - State behaviour and all other outputs are identical.

## Structure
- Shared package `traffic_pkg`:
  - light code constants LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001, shared with the traffic light FSM
  - pedestrian state enum `ped_state_t` {IDLE, WALK, FLASH}
- Sub-module `rise_edge_detect`: one-register rising-edge detector with async active-high reset. Used for `ped_btn`.

## Test plan
- Basic grant:
  - Stimulus: reset, `light`=001, pulse `ped_btn` 1 cycle, then `light`=010 for 2 cycles, then 100 held.
  - Expect: `req_pending`=1 after the press. `walk`=1 for 8 cycles starting one cycle after red entry, with `countdown` 7 down to 0. Then `walk_flash` for 4 cycles (3 down to 0), then `dont_walk`=1 and `req_pending`=0.
- No request: cycle 001 → 010 → 100 repeatedly with no press. Expect `dont_walk` to stay 1 and `walk` never 1.
- Abort:
  - Stimulus: grant started, `light` changes to 001 on the 3rd WALK cycle.
  - Expect: `dont_walk`=1 on the next cycle, `countdown`=0, `req_pending`=0.
- Simultaneous:
  - Stimulus: `ped_btn` rising in the same cycle as a red entry with a request already pending.
  - Expect: WALK starts and `req_pending` remains 1. A walk is granted again at the next red entry.
- Fault:
  - Stimulus: `light`=110 for 1 cycle during WALK, then legal codes.
  - Expect: `fault`=1 and `dont_walk`=1 next cycle, both persisting. No further walks until reset.
- Reset:
  - Stimulus: assert `reset` mid-FLASH, release with `light`=100 held.
  - Expect: all outputs at reset values and no walk, because this is not a red entry.
